// File: rtl/input_debounce.sv
// Per-channel synchroniser and debouncer for mechanical inputs.
// Produces clean levels plus registered single-cycle rise/fall strobes.
module input_debounce #(
  parameter int WIDTH       = 4,
  parameter int CNT_BITS    = 16,
  parameter int SYNC_STAGES = 2,   // minimum 2
  parameter int ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam logic                IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_BITS-1:0]    ctr_q, ctr_d;
  logic [WIDTH-1:0]                  level_q, level_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              any_q, any_d;
  logic [WIDTH-1:0]                  s;

  always_comb begin
    sync_d[0] = raw_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Polarity is folded in after the last stage so level_out=1 always means asserted.
  assign s = sync_q[SYNC_STAGES-1] ^ {WIDTH{IDLE_LVL}};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    ctr_d   = ctr_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      if (s[ch] == level_q[ch]) begin
        ctr_d[ch] = '0;
      end else if (ctr_q[ch] != CNT_MAX) begin
        ctr_d[ch] = ctr_q[ch] + 1'b1;
      end else begin
        ctr_d[ch]   = '0;
        level_d[ch] = s[ch];
        rise_d[ch]  = s[ch];
        fall_d[ch]  = ~s[ch];
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Synchroniser resets to the idle pin level so release never looks like an edge.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!resetn) begin
      sync_q  <= {(SYNC_STAGES*WIDTH){IDLE_LVL}};
      ctr_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ctr_q   <= ctr_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: table of step/glitch vectors with an event scoreboard,
// plus hand sequences for simultaneous channels, mid-count reset and active-low.
module tb_input_debounce;

  localparam int LAT = 18;  // SYNC_STAGES + 2^CNT_BITS with CNT_BITS=4

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] raw0 = 4'hF, raw1 = 4'hF;
  logic [3:0] level0, rise0, fall0, level1, rise1, fall1;
  logic       any0, any1;

  always #5 clk = ~clk;

  input_debounce #(.WIDTH(4), .CNT_BITS(4), .SYNC_STAGES(2), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .resetn(resetn), .raw_in(raw0), .level_out(level0),
    .rise_pulse(rise0), .fall_pulse(fall0), .any_change(any0));

  input_debounce #(.WIDTH(4), .CNT_BITS(4), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .resetn(resetn), .raw_in(raw1), .level_out(level1),
    .rise_pulse(rise1), .fall_pulse(fall1), .any_change(any1));

  typedef struct {
    int         due;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
  } event_t;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic [3:0] exp_level;
  } vec_t;

  event_t     sb[$];
  logic [3:0] ev_level = 4'h0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       al_phase = 1'b0;
  logic       al_evt_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [3:0] rise, input logic [3:0] fall);
    event_t e;
    ev_level = (ev_level & ~fall) | rise;
    e.due    = cyc + LAT;
    e.rise   = rise;
    e.fall   = fall;
    e.level  = ev_level;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every observed strobe must match the next queued event.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due < cyc) begin
      check("missed_event_cycle", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if ((rise0 | fall0) != 4'h0 || any0) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {23'd0, any0, rise0, fall0}, 32'd0);
      end else begin
        event_t e;
        e = sb.pop_front();
        check("ev_cycle", cyc, e.due);
        check("ev_rise", rise0, e.rise);
        check("ev_fall", fall0, e.fall);
        check("ev_level", level0, e.level);
        check("ev_any", any0, 1'b1);
        check("ev_rise_and_fall", rise0 & fall0, 4'h0);
      end
    end
    if (!al_phase && (any1 || (rise1 | fall1) != 4'h0)) al_evt_seen <= 1'b1;
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'h0, 20, 4'h0, 4'hF, 4'h0};  // release all
    vecs[1] = '{4'h1, 15, 4'h0, 4'h0, 4'h0};  // 15-cycle glitch rejected
    vecs[2] = '{4'h0, 20, 4'h0, 4'h0, 4'h0};
    vecs[3] = '{4'h1, 16, 4'h1, 4'h0, 4'h0};  // 16 cycles is enough; change lands later
    vecs[4] = '{4'h0, 20, 4'h0, 4'h1, 4'h0};
    vecs[5] = '{4'h2, 20, 4'h2, 4'h0, 4'h2};
    vecs[6] = '{4'h0, 20, 4'h0, 4'h2, 4'h0};  // channel 1 release
    vecs[7] = '{4'hA, 20, 4'hA, 4'h0, 4'hA};

    // Reset with inputs held asserted.
    repeat (3) @(negedge clk);
    check("rst_level", level0, 4'h0);
    check("rst_rise", rise0, 4'h0);
    check("rst_fall", fall0, 4'h0);
    check("rst_any", any0, 1'b0);
    check("rst_level_al", level1, 4'h0);
    resetn = 1'b1;
    push_ev(4'hF, 4'h0);
    repeat (20) @(negedge clk);
    check("post_rst_level", level0, 4'hF);

    foreach (vecs[i]) begin
      raw0 = vecs[i].raw;
      if ((vecs[i].exp_rise | vecs[i].exp_fall) != 4'h0)
        push_ev(vecs[i].exp_rise, vecs[i].exp_fall);
      repeat (vecs[i].hold) @(negedge clk);
      check($sformatf("vec%0d_level", i), level0, vecs[i].exp_level);
    end

    // Channels 2 and 3 rise together while channel 0 chatters every 5 cycles.
    raw0 = 4'h0;
    ev_level = 4'h0;
    push_ev(4'h0, 4'hA);
    repeat (20) @(negedge clk);
    raw0 = 4'hC;
    push_ev(4'hC, 4'h0);
    for (int k = 0; k < 6; k++) begin
      repeat (5) @(negedge clk);
      raw0[0] = ~raw0[0];
    end
    repeat (5) @(negedge clk);
    check("simul_level", level0, 4'hC);

    // Reset mid-count, asserted between edges.
    raw0 = 4'hD;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_level", level0, 4'h0);
    check("midrst_rise", rise0, 4'h0);
    check("midrst_any", any0, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    ev_level = 4'h0;
    push_ev(4'hD, 4'h0);
    repeat (20) @(negedge clk);
    check("midrst_relatch_level", level0, 4'hD);

    // Active-low instance: idle-high pins never produced an event.
    al_phase = 1'b1;
    check("al_no_event", al_evt_seen, 1'b0);
    check("al_idle_level", level1, 4'h0);
    raw1 = 4'hE;
    repeat (LAT - 1) @(negedge clk);
    check("al_before_level", level1, 4'h0);
    @(negedge clk);
    check("al_level", level1, 4'h1);
    check("al_rise", rise1, 4'h1);
    check("al_fall", fall1, 4'h0);
    check("al_any", any1, 1'b1);
    @(negedge clk);
    check("al_rise_one_cycle", rise1, 4'h0);
    check("al_any_one_cycle", any1, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
